// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_if
// Brief    : ROM fetch bus plus IF/ID valid/ready handshake for inst_fetch.
// Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_inst;
    logic              id_valid;
    logic              id_ready;
    logic [ADDR_W-1:0] id_pc;
    logic [INST_W-1:0] id_inst;

    modport master (
        output rom_ce, rom_addr, id_valid, id_pc, id_inst,
        input  rom_inst, id_ready
    );

    modport slave (
        input  rom_ce, rom_addr, id_valid, id_pc, id_inst,
        output rom_inst, id_ready
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Brief    : PC owner and ROM fetch initiator with a 2-entry prefetch buffer
//            feeding decode; handles halt and flush redirects.
//            Optional macro BRANCH_DELAY_SLOT_EN keeps the delay-slot
//            instruction across a flush.
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire                clk,
    input  wire                rst,
    input  wire                halt_i,
    input  wire                flush_i,
    input  wire   [ADDR_W-1:0] flush_pc_i,
    inst_fetch_if.master       bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        count;
    logic [ADDR_W-1:0] e0_pc;
    logic [INST_W-1:0] e0_inst;
    logic [ADDR_W-1:0] e1_pc;
    logic [INST_W-1:0] e1_inst;

    logic              has_data;
    logic              fetch_en;
    logic              pop;
    logic              do_flush;
    logic [ADDR_W-1:0] flush_target;

    assign has_data     = (count != 2'd0);
    // A full buffer may still fetch when decode frees a slot in the same cycle.
    assign fetch_en     = (state == FETCH) && !halt_i &&
                          ((count != 2'd2) || bus.id_ready);
    assign pop          = has_data && bus.id_ready;
    assign do_flush     = flush_i && (state != IDLE);
    assign flush_target = flush_pc_i & ALIGN_MASK;

    assign bus.rom_ce   = fetch_en;
    assign bus.rom_addr = pc;
    assign bus.id_valid = has_data;
    assign bus.id_pc    = e0_pc;
    assign bus.id_inst  = e0_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            count   <= 2'd0;
            e0_pc   <= '0;
            e0_inst <= '0;
            e1_pc   <= '0;
            e1_inst <= '0;
        end else begin
            case (state)
                IDLE:    state <= halt_i ? HALT : FETCH;
                FETCH:   if (halt_i)  state <= HALT;
                HALT:    if (!halt_i) state <= FETCH;
                default: state <= IDLE;
            endcase

            if (do_flush) begin
                pc <= flush_target;
`ifdef BRANCH_DELAY_SLOT_EN
                // Keep the delay-slot instruction: the current head, or the
                // word being fetched right now when nothing is buffered.
                if (has_data) begin
                    count   <= 2'd1;
                    e1_pc   <= '0;
                    e1_inst <= '0;
                end else if (fetch_en) begin
                    count   <= 2'd1;
                    e0_pc   <= pc;
                    e0_inst <= bus.rom_inst;
                end
`else
                count   <= 2'd0;
                e0_pc   <= '0;
                e0_inst <= '0;
                e1_pc   <= '0;
                e1_inst <= '0;
`endif
            end else begin
                if (fetch_en) begin
                    pc <= pc + ADDR_W'(4);
                end

                // Entry 1 is kept zero whenever fewer than two are held, so
                // shifting it into the head also clears an emptied buffer.
                case ({fetch_en, pop})
                    2'b10: begin
                        count <= count + 2'd1;
                        if (count == 2'd0) begin
                            e0_pc   <= pc;
                            e0_inst <= bus.rom_inst;
                        end else begin
                            e1_pc   <= pc;
                            e1_inst <= bus.rom_inst;
                        end
                    end
                    2'b01: begin
                        count   <= count - 2'd1;
                        e0_pc   <= e1_pc;
                        e0_inst <= e1_inst;
                        e1_pc   <= '0;
                        e1_inst <= '0;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            e0_pc   <= pc;
                            e0_inst <= bus.rom_inst;
                        end else begin
                            e0_pc   <= e1_pc;
                            e0_inst <= e1_inst;
                            e1_pc   <= pc;
                            e1_inst <= bus.rom_inst;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
